// File: rtl/boot_rom_loader.sv
// Copies LOAD_WORDS words from an instruction ROM into instruction memory.
// The core is held in stall until the image is resident, and a running checksum is kept.
module boot_rom_loader #(
  parameter int LOAD_WORDS = 1024,
  parameter int AUTO_START = 1
) (
  input  logic        clk,
  input  logic        sync_rst,
  input  logic        clk_en,
  output logic [9:0]  RomAddress,
  input  logic [15:0] RomValue,
  output logic        MemWriteEn,
  output logic [9:0]  MemWriteAddr,
  output logic [15:0] MemWriteData,
  input  logic        MemWriteReady,
  input  logic        ReloadReq,
  output logic        CoreHold,
  output logic        LoadDone,
  output logic [15:0] Checksum
);

  localparam logic [9:0] LAST_WORD = 10'(LOAD_WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_COPY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [9:0]  count_q, count_d;
  logic [15:0] checksum_q, checksum_d;

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      state_q    <= S_IDLE;
      count_q    <= 10'd0;
      checksum_q <= 16'd0;
    end else if (clk_en) begin
      state_q    <= state_d;
      count_q    <= count_d;
      checksum_q <= checksum_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    checksum_d   = checksum_q;
    RomAddress   = 10'd0;
    MemWriteEn   = 1'b0;
    MemWriteAddr = 10'd0;
    MemWriteData = 16'd0;
    CoreHold     = 1'b1;
    LoadDone     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (clk_en && ((AUTO_START != 0) || ReloadReq)) begin
          state_d    = S_COPY;
          count_d    = 10'd0;
          checksum_d = 16'd0;
        end
      end

      S_COPY: begin
        // Address and data come straight from the counter, so a stalled write holds them stable.
        RomAddress   = count_q;
        MemWriteAddr = count_q;
        MemWriteData = RomValue;
        MemWriteEn   = clk_en;
        if (clk_en && MemWriteReady) begin
          checksum_d = checksum_q + RomValue;
          if (count_q == LAST_WORD) begin
            state_d = S_DONE;
            count_d = 10'd0;
          end else begin
            count_d = count_q + 10'd1;
          end
        end
      end

      S_DONE: begin
        CoreHold = 1'b0;
        LoadDone = 1'b1;
        if (clk_en && ReloadReq) begin
          state_d    = S_COPY;
          count_d    = 10'd0;
          checksum_d = 16'd0;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign Checksum = checksum_q;

endmodule

// File: doc/boot_rom_loader.md
BOOT_ROM_LOADER -- requirements
Module: boot_rom_loader

Interface
REQ-001 SHALL have parameter LOAD_WORDS, default 1024, which is the number of ROM words copied per load (legal range 1..1024).
REQ-002 SHALL have parameter AUTO_START, default 1: 1 = begin a copy automatically after reset, 0 = wait for ReloadReq.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 sync_rst  input  1  reset, synchronous and active-high.
REQ-005 clk_en  input  1  global clock enable; when low, all registered state holds.
REQ-006 RomAddress  output  10  word address driven to the instruction ROM.
REQ-007 RomValue  input  16  ROM read data, combinational from RomAddress (zero latency).
REQ-008 MemWriteEn  output  1  write-valid to instruction memory.
REQ-009 MemWriteAddr  output  10  instruction-memory write address.
REQ-010 MemWriteData  output  16  instruction-memory write data.
REQ-011 MemWriteReady  input  1  instruction memory accepts the write this cycle.
REQ-012 ReloadReq  input  1  request a fresh copy; sampled in IDLE and DONE only.
REQ-013 CoreHold  output  1  holds the core in stall while high.
REQ-014 LoadDone  output  1  high while a completed image is resident.
REQ-015 Checksum  output  16  modulo-2^16 sum of all words copied in the current or last load.

Function
REQ-016 SHALL implement three states: IDLE, COPY and DONE.
REQ-017 SHALL have a 10-bit word counter Count that selects the next word to copy.
REQ-018 IDLE: if clk_en and (AUTO_START==1 or ReloadReq), SHALL go to COPY on the next edge with Count=0 and Checksum=0.
REQ-019 COPY: RomAddress=Count, MemWriteAddr=Count, MemWriteData=RomValue, and MemWriteEn=clk_en, all driven combinationally.
REQ-020 A transfer SHALL occur when MemWriteEn and MemWriteReady are both high; a transfer does Checksum <= Checksum+RomValue (carry dropped) and Count <= Count+1.
REQ-021 While MemWriteReady is low, address and data SHALL hold stable, and Count and Checksum SHALL not change.
REQ-022 A transfer with Count==LOAD_WORDS-1 SHALL move the block to DONE with Count=0; no word beyond LOAD_WORDS-1 is ever written.
REQ-023 DONE: CoreHold=0 and LoadDone=1; if clk_en and ReloadReq, SHALL go to COPY with Count=0 and Checksum=0.
REQ-024 DONE SHALL never restart on its own, regardless of AUTO_START.
REQ-025 CoreHold SHALL be 1 in IDLE and COPY; LoadDone SHALL be 0 in IDLE and COPY.
REQ-026 Outside COPY: MemWriteEn=0, RomAddress=0, MemWriteAddr=0, MemWriteData=0.
REQ-027 ReloadReq SHALL be ignored during COPY.
REQ-028 Checksum SHALL be registered and hold its final value through DONE.
REQ-029 With MemWriteReady held high and clk_en=1, a load SHALL take exactly LOAD_WORDS cycles in COPY.

Reset
REQ-030 sync_rst high at an edge SHALL force, in priority over clk_en and every other input: State=IDLE, Count=0, Checksum=0, CoreHold=1, LoadDone=0, MemWriteEn=0, RomAddress=0.
REQ-031 Reset mid-COPY SHALL abandon the load; the next load SHALL restart from address 0.

Verification
REQ-032 Basic load: LOAD_WORDS=4, ROM[0..3] = D188, C220, E2E1, C3E4, Ready=1, reset released at cycle 0.
  - Writes addr 0..3 in cycles 1..4.
  - LoadDone=1 and CoreHold=0 from cycle 5.
  - Checksum=3A6D.
REQ-033 Backpressure: same setup, MemWriteReady=0 for 3 cycles while addr 2 is presented.
  - MemWriteAddr=2 and MemWriteData=E2E1 stay stable throughout.
  - DONE is reached 3 cycles late; Checksum=3A6D.
REQ-034 clk_en low for 2 cycles mid-COPY.
  - MemWriteEn=0 and no state change during those cycles.
  - Load then completes with Checksum=3A6D.
REQ-035 Reload: ReloadReq pulsed during COPY.
  - Pulse ignored; copy proceeds unchanged.
  - A later pulse in DONE gives CoreHold=1, a full recopy of addr 0..3, and Checksum=3A6D.
REQ-036 Reset at addr 2 mid-COPY.
  - All outputs return to reset values.
  - With AUTO_START=0: block stays IDLE with MemWriteEn=0 until ReloadReq, then copies from addr 0.
